matraptor_row_drain: RTL and testbench
======================================

Name: matraptor_row_drain

Overview:
- Output-side counterpart to the PE fill path. After a PE signals row_done, this block drains that PE's NQ column-sorted queues.
- It performs an NQ-way merge on column index and sums entries with equal columns. It emits <val,row,col> triples on a ready/valid stream, with out_last on the final triple of the row.
- Sits between one PE's queue read heads and the result writer. It is the transmitter matching the triple receiver on the fill side.

Parameters:
- DATA_W, 32, value width; two's-complement integer accumulation.
- IDX_W, 16, row/column index width.
- NQ, 8, number of queues merged; must be ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- row_done  input  1  single-cycle pulse: this PE's queues hold a complete row.
- row_idx  input  IDX_W  row index; sampled when row_done=1.
- q_valid  input  NQ  per-queue head valid (queue non-empty).
- q_col  input  NQ*IDX_W  per-queue head column; queue q occupies slice [q*IDX_W +: IDX_W].
- q_val  input  NQ*DATA_W  per-queue head value.
- q_pop  output  NQ  one-hot pop; the head advances on the next clock.
- out_valid  output  1  output triple valid.
- out_ready  input  1  downstream accept.
- out_val  output  DATA_W  summed value.
- out_row  output  IDX_W  row index.
- out_col  output  IDX_W  column index.
- out_last  output  1  final triple of the row.
- busy  output  1  high from row_done acceptance until drain_done.
- drain_done  output  1  single-cycle pulse when the row has finished.
- out_count  output  IDX_W  beats accepted for the current row; cleared on each row_done acceptance.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. All outputs 0: q_pop, out_valid, out_val, out_row, out_col, out_last, busy, drain_done, out_count. Accumulator is invalid. Reset mid-row aborts the row with no further pops or beats.
- Handshakes:
  - A beat transfers when out_valid && out_ready.
  - Once raised, out_valid and the out_* fields hold stable until the transfer.
  - Output register is a single stage; it is "free" when !out_valid, or when out_valid && out_ready this cycle.
- IDLE:
  - row_done=1 → latch row_idx, clear out_count, busy=1, go MERGE.
  - row_done in any other state is ignored. Upstream must not pulse it while busy.
- MERGE, each cycle:
  - Select queue s = valid head with the smallest q_col; ties go to the lowest index. Selection is combinational.
  - Accumulator empty → pop s; acc ← {q_col[s], q_val[s]}.
  - Accumulator valid and q_col[s]==acc_col → pop s; acc_val ← acc_val + q_val[s]. Wraps modulo 2^DATA_W; never stalls.
  - Accumulator valid and q_col[s]!=acc_col:
    - If the output register is free: acc moves to the output register with out_last=0; pop s; acc ← the new head.
    - Otherwise: no pop (stall).
  - No q_valid bits set → go FLUSH.
- Pop timing: q_pop[s] is asserted combinationally in the same cycle as the selection.
- FLUSH:
  - Accumulator valid: when the output register is free, load acc with out_last=1, clear acc, go LAST.
  - Accumulator invalid (empty row): no beat; drain_done pulses next cycle; go IDLE.
- LAST: on the out_last beat transfer, drain_done=1 for one cycle, busy=0, go IDLE.
- out_count: increments on every transfer, saturating at all-ones.
- Throughput: one merged triple per cycle when out_ready is held 1. Latency from the first pop to the first out_valid is one cycle after the column changes.
- Simultaneous events: an output transfer and a load of the next triple in the same cycle are both allowed. out_valid stays 1 with the new data.

Optional Feature:
- SAT_ACC_EN:
  - Defined: the accumulator add is signed saturating. Overflow clamps to 2^(DATA_W-1)-1 and underflow to -2^(DATA_W-1). Once saturated, the value stays saturated within that column.
  - Undefined: the add wraps modulo 2^DATA_W.

Test Plan:
- Basic merge: q0={(1,c2),(4,c7)}, q1={(3,c5)}, row_idx=9, out_ready=1 → beats (1,9,2), (3,9,5), (4,9,7) with last on c7; out_count=3; one drain_done pulse.
- Duplicate columns: q0=(5,c3), q2=(6,c3), q5=(-2,c3) → single beat (9,row,3), out_last=1; pops in order q0, q2, q5.
- Backpressure: same stimulus as basic merge with out_ready toggling 1,0,0,1,... → out_* stable while out_ready=0; no pop while stalled; identical sequence of beats.
- Empty row: row_done with all q_valid=0 → no out_valid; drain_done two cycles after row_done; busy high for two cycles.
- Overflow: two entries 0x7FFFFFFF at c1 → out_val 0xFFFFFFFE without SAT_ACC_EN, 0x7FFFFFFF with it.
- Reset mid-row: rst pulsed after the first beat of the basic merge → all outputs 0 next cycle; the next row_done drains normally.

Source files
------------

// File: rtl/matraptor_row_drain.sv
// matraptor_row_drain: NQ-way column merge of one PE's sorted queues into a <val,row,col> stream
// Ports: row_done/row_idx start a row; q_valid/q_col/q_val are the queue heads, q_pop advances one head;
//   out_valid/out_ready/out_val/out_row/out_col/out_last form a single-stage triple stream;
//   busy/drain_done/out_count report row progress.
// Define SAT_ACC_EN for signed saturating accumulation; the default build wraps modulo 2^DATA_W.
module matraptor_row_drain #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int NQ     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 row_done,
  input  logic [IDX_W-1:0]     row_idx,
  input  logic [NQ-1:0]        q_valid,
  input  logic [NQ*IDX_W-1:0]  q_col,
  input  logic [NQ*DATA_W-1:0] q_val,
  output logic [NQ-1:0]        q_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_val,
  output logic [IDX_W-1:0]     out_row,
  output logic [IDX_W-1:0]     out_col,
  output logic                 out_last,
  output logic                 busy,
  output logic                 drain_done,
  output logic [IDX_W-1:0]     out_count
);
  localparam int SW = $clog2(NQ);
  typedef enum logic [1:0] {IDLE, MERGE, FLUSH, LAST} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d, acc_col_q, acc_col_d, out_row_q, out_row_d, out_col_q, out_col_d;
  logic [IDX_W-1:0] out_count_q, out_count_d;
  logic [DATA_W-1:0] acc_val_q, acc_val_d, out_val_q, out_val_d;
  logic acc_vld_q, acc_vld_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic busy_q, busy_d, drain_done_q, drain_done_d;
  logic [SW-1:0] sel;
  logic [IDX_W-1:0] sel_col;
  logic [DATA_W-1:0] sel_val, sum;
  logic any_v, same, free, xfer, ld;
  // strict < keeps the lowest-index queue on equal columns
  always_comb begin
    sel = '0;
    any_v = 1'b0;
    sel_col = '0;
    for (int i = 0; i < NQ; i++)
      if (q_valid[i] && (!any_v || q_col[i*IDX_W +: IDX_W] < sel_col)) begin
        any_v = 1'b1;
        sel = SW'(i);
        sel_col = q_col[i*IDX_W +: IDX_W];
      end
    sel_val = q_val[sel*DATA_W +: DATA_W];
  end
  assign same = state_q == MERGE && any_v && acc_vld_q && sel_col == acc_col_q;
  assign free = !out_valid_q || out_ready;
  assign xfer = out_valid_q && out_ready;
`ifdef SAT_ACC_EN
  logic acc_sat_q, acc_sat_d, ovf;
  logic [DATA_W:0] sum_x;
  // once a column has clamped it ignores further addends
  always_comb begin
    sum_x = {acc_val_q[DATA_W-1], acc_val_q} + {sel_val[DATA_W-1], sel_val};
    ovf = sum_x[DATA_W] ^ sum_x[DATA_W-1];
    sum = acc_sat_q ? acc_val_q : !ovf ? sum_x[DATA_W-1:0] : {sum_x[DATA_W], {(DATA_W-1){~sum_x[DATA_W]}}};
    acc_sat_d = same ? acc_sat_q | ovf : |q_pop ? 1'b0 : acc_sat_q;
  end
  always_ff @(posedge clk)
    if (rst) acc_sat_q <= 1'b0;
    else acc_sat_q <= acc_sat_d;
`else
  assign sum = acc_val_q + sel_val;
`endif
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    acc_vld_d = acc_vld_q;
    acc_col_d = acc_col_q;
    acc_val_d = acc_val_q;
    busy_d = busy_q;
    drain_done_d = 1'b0;
    q_pop = '0;
    ld = 1'b0;
    out_count_d = xfer && !(&out_count_q) ? out_count_q + 1'b1 : out_count_q;
    case (state_q)
      IDLE: if (row_done) begin
        row_d = row_idx;
        out_count_d = '0;
        busy_d = 1'b1;
        state_d = MERGE;
      end
      MERGE: if (!any_v) state_d = FLUSH;
        else if (!acc_vld_q || same || free) begin
          q_pop[sel] = 1'b1;
          ld = acc_vld_q && !same;
          acc_vld_d = 1'b1;
          acc_col_d = sel_col;
          acc_val_d = same ? sum : sel_val;
        end
      FLUSH: if (!acc_vld_q) begin
        drain_done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end else if (free) begin
        ld = 1'b1;
        acc_vld_d = 1'b0;
        state_d = LAST;
      end
      default: if (xfer) begin
        drain_done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    out_valid_d = ld || (out_valid_q && !out_ready);
    out_val_d = ld ? acc_val_q : out_val_q;
    out_row_d = ld ? row_q : out_row_q;
    out_col_d = ld ? acc_col_q : out_col_q;
    out_last_d = ld ? state_q == FLUSH : out_last_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      acc_vld_q <= 1'b0;
      acc_col_q <= '0;
      acc_val_q <= '0;
      out_valid_q <= 1'b0;
      out_val_q <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      out_last_q <= 1'b0;
      busy_q <= 1'b0;
      drain_done_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      acc_vld_q <= acc_vld_d;
      acc_col_q <= acc_col_d;
      acc_val_q <= acc_val_d;
      out_valid_q <= out_valid_d;
      out_val_q <= out_val_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      out_last_q <= out_last_d;
      busy_q <= busy_d;
      drain_done_q <= drain_done_d;
      out_count_q <= out_count_d;
    end
  assign out_valid = out_valid_q;
  assign out_val = out_val_q;
  assign out_row = out_row_q;
  assign out_col = out_col_q;
  assign out_last = out_last_q;
  assign busy = busy_q;
  assign drain_done = drain_done_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_matraptor_row_drain.sv
// tb_matraptor_row_drain: randomized self-checking bench with a queue-merge reference model
module tb_matraptor_row_drain;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int NQ = 8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  logic clk = 1'b0;
  logic rst, row_done, out_ready;
  logic [IW-1:0] row_idx;
  logic [NQ-1:0] q_valid, q_pop;
  logic [NQ*IW-1:0] q_col;
  logic [NQ*DW-1:0] q_val;
  logic out_valid, out_last, busy, drain_done;
  logic [DW-1:0] out_val;
  logic [IW-1:0] out_row, out_col, out_count;
  typedef struct {
    logic [DW-1:0] v;
    logic [IW-1:0] c;
    logic l;
  } beat_t;
  logic [IW-1:0] qc[NQ][$];
  logic [DW-1:0] qv[NQ][$];
  int hd[NQ];
  beat_t exp_b[$];
  int exp_p[$];
  int nexp;
  logic [DW-1:0] last_val;
  int n_chk = 0;
  int n_fail = 0;

  matraptor_row_drain dut (
    .clk(clk), .rst(rst), .row_done(row_done), .row_idx(row_idx),
    .q_valid(q_valid), .q_col(q_col), .q_val(q_val), .q_pop(q_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .drain_done(drain_done), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic clear_q();
    for (int q = 0; q < NQ; q++) begin
      qc[q].delete();
      qv[q].delete();
      hd[q] = 0;
    end
  endtask

  task automatic push(input int q, input logic [IW-1:0] c, input logic [DW-1:0] v);
    qc[q].push_back(c);
    qv[q].push_back(v);
  endtask

  // invalid heads carry random junk so the DUT must ignore them
  task automatic drive_heads();
    for (int q = 0; q < NQ; q++)
      if (hd[q] < qc[q].size()) begin
        q_valid[q] = 1'b1;
        q_col[q*IW +: IW] = qc[q][hd[q]];
        q_val[q*DW +: DW] = qv[q][hd[q]];
      end else begin
        q_valid[q] = 1'b0;
        q_col[q*IW +: IW] = IW'($urandom());
        q_val[q*DW +: DW] = $urandom();
      end
  endtask

  // merge the queue contents as a whole: repeatedly take the globally smallest head
  task automatic build_model(input logic [IW-1:0] row);
    int h[NQ];
    int best;
    bit have;
    logic [IW-1:0] acc_c;
    longint s;
    beat_t b;
`ifdef SAT_ACC_EN
    bit sat;
    sat = 0;
`endif
    exp_b.delete();
    exp_p.delete();
    have = 0;
    acc_c = '0;
    s = 0;
    for (int q = 0; q < NQ; q++) h[q] = 0;
    while (1) begin
      best = -1;
      for (int q = 0; q < NQ; q++)
        if (h[q] < qc[q].size() && (best < 0 || qc[q][h[q]] < qc[best][h[best]])) best = q;
      if (best < 0) break;
      exp_p.push_back(best);
      if (have && qc[best][h[best]] == acc_c) begin
`ifdef SAT_ACC_EN
        if (!sat) begin
          s = s + longint'($signed(qv[best][h[best]]));
          if (s > MAXV) begin s = MAXV; sat = 1; end
          else if (s < MINV) begin s = MINV; sat = 1; end
        end
`else
        s = s + longint'($signed(qv[best][h[best]]));
`endif
      end else begin
        if (have) begin
          b.v = s[DW-1:0]; b.c = acc_c; b.l = 1'b0;
          exp_b.push_back(b);
        end
        have = 1;
        acc_c = qc[best][h[best]];
        s = longint'($signed(qv[best][h[best]]));
`ifdef SAT_ACC_EN
        sat = 0;
`endif
      end
      h[best]++;
    end
    if (have) begin
      b.v = s[DW-1:0]; b.c = acc_c; b.l = 1'b1;
      exp_b.push_back(b);
    end
    nexp = exp_b.size();
  endtask

  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready
  task automatic run_row(input string name, input logic [IW-1:0] row, input int mode);
    logic pv, plast;
    logic [DW-1:0] pval;
    logic [IW-1:0] prow, pcol;
    logic [NQ-1:0] popv, ep;
    bit done;
    build_model(row);
    for (int q = 0; q < NQ; q++) hd[q] = 0;
    @(negedge clk);
    row_done = 1'b1;
    row_idx = row;
    out_ready = 1'b1;
    drive_heads();
    pv = 1'b0; plast = 1'b0; pval = '0; prow = '0; pcol = '0;
    done = 0;
    for (int cyc = 0; cyc < 500 && !done; cyc++) begin
      @(negedge clk);
      row_done = 1'b0;
      drive_heads();
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      popv = q_pop;
      if (pv) begin
        n_chk++;
        if ({out_valid, out_val, out_row, out_col, out_last} !== {1'b1, pval, prow, pcol, plast}) begin
          n_fail++;
          $display("FAIL %s hold: got v=%0b val=%0h row=%0d col=%0d last=%0b, required v=1 val=%0h row=%0d col=%0d last=%0b",
                   name, out_valid, out_val, out_row, out_col, out_last, pval, prow, pcol, plast);
        end
      end
      if (popv != '0) begin
        ep = exp_p.size() != 0 ? NQ'(1) << exp_p[0] : '0;
        n_chk++;
        if (popv !== ep) begin
          n_fail++;
          $display("FAIL %s pop: got %b, required %b", name, popv, ep);
        end
        if (exp_p.size() != 0) void'(exp_p.pop_front());
      end
      if (!drain_done) begin
        n_chk++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy: got %b, required 1", name, busy);
        end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        last_val = out_val;
        if (exp_b.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_beat: got val=%0h col=%0d, required no beat", name, out_val, out_col);
        end else begin
          if ({out_val, out_row, out_col, out_last} !== {exp_b[0].v, row, exp_b[0].c, exp_b[0].l}) begin
            n_fail++;
            $display("FAIL %s beat: got val=%0h row=%0d col=%0d last=%0b, required val=%0h row=%0d col=%0d last=%0b",
                     name, out_val, out_row, out_col, out_last, exp_b[0].v, row, exp_b[0].c, exp_b[0].l);
          end
          void'(exp_b.pop_front());
        end
      end
      pv = out_valid && !out_ready;
      pval = out_val; prow = out_row; pcol = out_col; plast = out_last;
      if (drain_done) done = 1;
      @(posedge clk);
      for (int q = 0; q < NQ; q++) if (popv[q]) hd[q]++;
    end
    n_chk++;
    if (!done || exp_b.size() != 0 || exp_p.size() != 0) begin
      n_fail++;
      $display("FAIL %s completion: got done=%0d beats_left=%0d pops_left=%0d, required done=1 beats_left=0 pops_left=0",
               name, done, exp_b.size(), exp_p.size());
    end
    n_chk++;
    if (out_count !== IW'(nexp)) begin
      n_fail++;
      $display("FAIL %s out_count: got %0d, required %0d", name, out_count, nexp);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({drain_done, busy, out_valid, q_pop} !== '0) begin
      n_fail++;
      $display("FAIL %s after_done: got drain_done=%b busy=%b out_valid=%b q_pop=%b, required all 0",
               name, drain_done, busy, out_valid, q_pop);
    end
  endtask

  task automatic load_basic();
    clear_q();
    push(0, 2, 1);
    push(0, 7, 4);
    push(1, 5, 3);
  endtask

  task automatic check_zero(input string name);
    n_chk++;
    if ({q_pop, out_valid, out_val, out_row, out_col, out_last, busy, drain_done, out_count} !== '0) begin
      n_fail++;
      $display("FAIL %s: got q_pop=%b out_valid=%b val=%0h row=%0d col=%0d last=%b busy=%b dd=%b cnt=%0d, required all 0",
               name, q_pop, out_valid, out_val, out_row, out_col, out_last, busy, drain_done, out_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    row_done = 1'b0;
    row_idx = '0;
    out_ready = 1'b0;
    load_basic();
    drive_heads();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    #1;
    check_zero("idle_no_pop");
  endtask

  task automatic test_basic_merge();
    load_basic();
    run_row("basic", 9, 0);
  endtask

  task automatic test_duplicates();
    clear_q();
    push(0, 3, 5);
    push(2, 3, 6);
    push(5, 3, -32'sd2);
    run_row("dup", 4, 0);
    n_chk++;
    if (last_val !== 32'd9) begin
      n_fail++;
      $display("FAIL dup_sum: got %0h, required 9", last_val);
    end
  endtask

  task automatic test_backpressure();
    load_basic();
    run_row("backpressure", 9, 1);
    load_basic();
    run_row("backpressure_rand", 9, 2);
  endtask

  task automatic test_empty_row();
    logic [2:0] exp_busy, exp_dd;
    clear_q();
    @(negedge clk);
    row_done = 1'b1;
    row_idx = 12;
    out_ready = 1'b1;
    drive_heads();
    exp_busy = 3'b011;
    exp_dd = 3'b100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      row_done = 1'b0;
      drive_heads();
      #1;
      n_chk++;
      if (busy !== (k < 3 && exp_busy[k]) || drain_done !== (k < 3 && exp_dd[k]) || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_row cycle %0d: got busy=%b drain_done=%b out_valid=%b, required busy=%b drain_done=%b out_valid=0",
                 k + 1, busy, drain_done, out_valid, k < 3 && exp_busy[k], k < 3 && exp_dd[k]);
      end
    end
    clear_q();
    run_row("empty_row_model", 13, 2);
  endtask

  task automatic test_overflow();
    logic [DW-1:0] want;
`ifdef SAT_ACC_EN
    want = 32'h7FFFFFFF;
`else
    want = 32'hFFFFFFFE;
`endif
    clear_q();
    push(0, 1, 32'h7FFFFFFF);
    push(1, 1, 32'h7FFFFFFF);
    run_row("overflow", 3, 0);
    n_chk++;
    if (last_val !== want) begin
      n_fail++;
      $display("FAIL overflow_val: got %0h, required %0h", last_val, want);
    end
    clear_q();
    push(3, 6, 32'h80000000);
    push(4, 6, 32'hFFFFFFFF);
    push(4, 6, 32'h00000005);
    run_row("underflow", 3, 2);
  endtask

  task automatic test_reset_mid_row();
    logic [NQ-1:0] popv;
    bit seen;
    load_basic();
    for (int q = 0; q < NQ; q++) hd[q] = 0;
    @(negedge clk);
    row_done = 1'b1;
    row_idx = 9;
    out_ready = 1'b1;
    drive_heads();
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      row_done = 1'b0;
      drive_heads();
      #1;
      popv = q_pop;
      if (out_valid && out_ready) seen = 1;
      @(posedge clk);
      for (int q = 0; q < NQ; q++) if (popv[q]) hd[q]++;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reset_mid_row first_beat: got none within 50 cycles, required one");
    end
    @(negedge clk);
    rst = 1'b1;
    drive_heads();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("reset_mid_row");
    @(negedge clk);
    #1;
    check_zero("reset_mid_row_idle");
    load_basic();
    run_row("after_reset", 9, 0);
  endtask

  task automatic test_random();
    int n, m;
    logic [IW-1:0] c;
    logic [DW-1:0] v;
    for (int r = 0; r < 8; r++) begin
      clear_q();
      for (int q = 0; q < NQ; q++) begin
        n = $urandom_range(0, 4);
        c = IW'($urandom_range(0, 5));
        for (int k = 0; k < n; k++) begin
          c = c + IW'($urandom_range(0, 3));
          v = $urandom_range(0, 3) == 0 ? $urandom() : DW'($urandom_range(0, 20)) - 32'd10;
          push(q, c, v);
        end
      end
      m = $urandom_range(0, 2);
      run_row("random", IW'($urandom()), m);
    end
  endtask

  initial begin
    test_reset();
    test_basic_merge();
    test_duplicates();
    test_backpressure();
    test_empty_row();
    test_overflow();
    test_reset_mid_row();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
